// File: rtl/hazard_ctrl_pkg.sv
// Shared types, cycle defaults and helpers for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

   localparam int MULT_CYCLES_DEF = 4;
   localparam int DIV_CYCLES_DEF  = 33;
   localparam int CNT_W_DEF       = 6;

   typedef enum logic {
      HZ_IDLE    = 1'b0,
      HZ_MD_BUSY = 1'b1
   } hz_state_t;

   // A producer register conflicts with an ID-stage source unless it is $0.
   function automatic logic reg_hit(input logic [4:0] rd,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt);
      return (rd != 5'd0) && ((rd == rs) || (rd == rt));
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-side hazard inputs and stall/flush controls.
// Latency: n/a (wires only).
// Backpressure: the slave side holds the front end via pcWrite/ifIdWrite/idExWrite.
interface hazard_ctrl_if;
   logic [4:0] rs_ID;
   logic [4:0] rt_ID;
   logic       branch_ID;
   logic       memRead_ID_EX;
   logic       ctrlRegWrite_ID_EX;
   logic [4:0] rd_ID_EX;
   logic       memRead_EX_MEM;
   logic [4:0] rd_EX_MEM;
   logic       branchTaken_ID;
   logic       mdStart_EX;
   logic       mdIsDiv_EX;
   logic       pcWrite;
   logic       ifIdWrite;
   logic       idExWrite;
   logic       idExBubble;
   logic       ifIdFlush;
   logic       mdBusy;
   logic       mdDone;

   modport master (
      output rs_ID, rt_ID, branch_ID, memRead_ID_EX, ctrlRegWrite_ID_EX, rd_ID_EX,
             memRead_EX_MEM, rd_EX_MEM, branchTaken_ID, mdStart_EX, mdIsDiv_EX,
      input  pcWrite, ifIdWrite, idExWrite, idExBubble, ifIdFlush, mdBusy, mdDone
   );

   modport slave (
      input  rs_ID, rt_ID, branch_ID, memRead_ID_EX, ctrlRegWrite_ID_EX, rd_ID_EX,
             memRead_EX_MEM, rd_EX_MEM, branchTaken_ID, mdStart_EX, mdIsDiv_EX,
      output pcWrite, ifIdWrite, idExWrite, idExBubble, ifIdFlush, mdBusy, mdDone
   );
endinterface

// File: rtl/hazard_ctrl_md_busy_counter.sv
// MULT/DIV occupancy counter: load, decrement towards zero, zero flag.
// Latency: load/decrement visible one cycle later; zero flag is combinational on cnt.
// Backpressure: none; decrement saturates at zero so the count never wraps.
module md_busy_counter #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   // Counter register: reset wins, then load, then saturating decrement.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: MULT/DIV hold, load-use bubble, branch operand stall, taken-branch flush.
// Latency: all controls combinational from inputs and FSM state; MULT/DIV hold lasts the configured cycle count.
// Backpressure: drops pcWrite/ifIdWrite (and idExWrite for MULT/DIV) to hold the front end.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   hazard_ctrl_if.slave  bus
);

   if ((MULT_CYCLES < 2) || (DIV_CYCLES < 2) ||
       (MULT_CYCLES >= (1 << CNT_W)) || (DIV_CYCLES >= (1 << CNT_W))) begin : g_bad_cfg
      $error("hazard_ctrl: MULT_CYCLES/DIV_CYCLES must be >= 2 and fit in CNT_W bits");
   end

   // The start cycle is the first stall cycle, so the counter covers the remaining N-1.
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 2);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);

   hz_state_t        state, state_nxt;
   logic [CNT_W-1:0] cnt, load_val;
   logic             cnt_zero, cnt_load, cnt_dec;
   logic             md_stall, md_done, lu_stall, br_stall, flush;

   md_busy_counter #(.CNT_W(CNT_W)) u_md_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (load_val),
      .dec      (cnt_dec),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   assign load_val = bus.mdIsDiv_EX ? DIV_LOAD : MULT_LOAD;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HZ_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state and counter control; a start seen while busy is ignored.
   always_comb begin
      state_nxt = state;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      md_stall  = 1'b0;
      md_done   = 1'b0;
      case (state)
         HZ_IDLE: begin
            if (bus.mdStart_EX) begin
               md_stall  = 1'b1;
               cnt_load  = 1'b1;
               state_nxt = HZ_MD_BUSY;
            end
         end
         HZ_MD_BUSY: begin
            md_stall = 1'b1;
            if (cnt_zero) begin
               md_done   = 1'b1;
               state_nxt = HZ_IDLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_nxt = HZ_IDLE;
      endcase
   end

   // Hazard detection in priority order: MULT/DIV > load-use > branch operand > flush.
   always_comb begin
      lu_stall = ~md_stall & bus.memRead_ID_EX & reg_hit(bus.rd_ID_EX, bus.rs_ID, bus.rt_ID);
      br_stall = ~md_stall & ~lu_stall & bus.branch_ID &
                 ((bus.ctrlRegWrite_ID_EX & reg_hit(bus.rd_ID_EX, bus.rs_ID, bus.rt_ID)) |
                  (bus.memRead_EX_MEM & reg_hit(bus.rd_EX_MEM, bus.rs_ID, bus.rt_ID)));
      flush    = bus.branchTaken_ID & ~md_stall & ~lu_stall & ~br_stall;
   end

   // Output drive; reset forces the free-running values immediately, even mid MULT/DIV.
   always_comb begin
      bus.pcWrite    = 1'b1;
      bus.ifIdWrite  = 1'b1;
      bus.idExWrite  = 1'b1;
      bus.idExBubble = 1'b0;
      bus.ifIdFlush  = 1'b0;
      bus.mdBusy     = 1'b0;
      bus.mdDone     = 1'b0;
      if (!rst) begin
         bus.mdBusy = md_stall;
         bus.mdDone = md_done;
         if (md_stall) begin
            bus.pcWrite   = 1'b0;
            bus.ifIdWrite = 1'b0;
            bus.idExWrite = 1'b0;
         end else if (lu_stall || br_stall) begin
            bus.pcWrite    = 1'b0;
            bus.ifIdWrite  = 1'b0;
            bus.idExBubble = 1'b1;
         end
         bus.ifIdFlush = flush;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic against a behavioural model.
// Latency: checks sampled 1 time unit after each falling edge.
// Backpressure: n/a.
module tb_hazard_ctrl;

   localparam int MULT_N = 4;
   localparam int DIV_N  = 33;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hazard_ctrl_if bus ();

   hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Model: number of MULT/DIV stall cycles still owed after the current one.
   int   md_rem = 0;
   logic e_pc, e_ifid, e_idex, e_bub, e_flush, e_busy, e_done;
   logic o_pc, o_ifid, o_idex, o_bub, o_flush, o_busy, o_done;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic hits(input logic [4:0] rd);
      return (rd != 5'd0) && (rd == bus.rs_ID || rd == bus.rt_ID);
   endfunction

   task automatic model_eval();
      logic md, lu, br;
      e_pc = 1'b1; e_ifid = 1'b1; e_idex = 1'b1; e_bub = 1'b0;
      e_flush = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      if (!rst) begin
         md = (md_rem > 0) || bus.mdStart_EX;
         e_done = (md_rem == 1);
         lu = !md && bus.memRead_ID_EX && hits(bus.rd_ID_EX);
         br = !md && !lu && bus.branch_ID &&
              ((bus.ctrlRegWrite_ID_EX && hits(bus.rd_ID_EX)) ||
               (bus.memRead_EX_MEM && hits(bus.rd_EX_MEM)));
         if (md) begin
            e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_busy = 1'b1;
         end else if (lu || br) begin
            e_pc = 1'b0; e_ifid = 1'b0; e_bub = 1'b1;
         end
         e_flush = bus.branchTaken_ID && !md && !lu && !br;
      end
   endtask

   task automatic model_update();
      if (rst)             md_rem = 0;
      else if (md_rem > 0) md_rem = md_rem - 1;
      else if (bus.mdStart_EX) md_rem = (bus.mdIsDiv_EX ? DIV_N : MULT_N) - 1;
   endtask

   // One clock: entered at a falling edge with inputs driven, leaves at the next falling edge.
   task automatic tick(input string tag);
      #1;
      o_pc = bus.pcWrite; o_ifid = bus.ifIdWrite; o_idex = bus.idExWrite;
      o_bub = bus.idExBubble; o_flush = bus.ifIdFlush; o_busy = bus.mdBusy; o_done = bus.mdDone;
      model_eval();
      chk({tag, ".pcWrite"},    o_pc,    e_pc);
      chk({tag, ".ifIdWrite"},  o_ifid,  e_ifid);
      chk({tag, ".idExWrite"},  o_idex,  e_idex);
      chk({tag, ".idExBubble"}, o_bub,   e_bub);
      chk({tag, ".ifIdFlush"},  o_flush, e_flush);
      chk({tag, ".mdBusy"},     o_busy,  e_busy);
      chk({tag, ".mdDone"},     o_done,  e_done);
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic drive_zero();
      bus.rs_ID = '0; bus.rt_ID = '0; bus.branch_ID = 1'b0;
      bus.memRead_ID_EX = 1'b0; bus.ctrlRegWrite_ID_EX = 1'b0; bus.rd_ID_EX = '0;
      bus.memRead_EX_MEM = 1'b0; bus.rd_EX_MEM = '0; bus.branchTaken_ID = 1'b0;
      bus.mdStart_EX = 1'b0; bus.mdIsDiv_EX = 1'b0;
   endtask

   // Small register range so dependencies (and $0) come up often.
   task automatic drive_random(input int md_pct);
      bus.rs_ID = 5'($urandom_range(0, 3));
      bus.rt_ID = 5'($urandom_range(0, 3));
      bus.rd_ID_EX = 5'($urandom_range(0, 3));
      bus.rd_EX_MEM = 5'($urandom_range(0, 3));
      bus.branch_ID = 1'($urandom_range(0, 1));
      bus.memRead_ID_EX = 1'($urandom_range(0, 1));
      bus.ctrlRegWrite_ID_EX = 1'($urandom_range(0, 1));
      bus.memRead_EX_MEM = 1'($urandom_range(0, 1));
      bus.branchTaken_ID = 1'($urandom_range(0, 1));
      bus.mdStart_EX = ($urandom_range(0, 99) < md_pct);
      bus.mdIsDiv_EX = 1'($urandom_range(0, 1));
   endtask

   // Launch a MULT/DIV and measure stall length, mdDone position and PC release cycle.
   task automatic md_run(input logic is_div, input int n, input string tag);
      int stalls, done_at, done_cnt, free_at;
      stalls = 0; done_at = 0; done_cnt = 0; free_at = 0;
      drive_zero();
      bus.mdStart_EX = 1'b1;
      bus.mdIsDiv_EX = is_div;
      for (int i = 1; i <= n + 3; i++) begin
         tick(tag);
         if (!o_pc) stalls++;
         if (o_done) begin done_cnt++; done_at = i; end
         if (o_pc && free_at == 0) free_at = i;
         drive_zero();
      end
      chk_int({tag, ".stall_len"}, stalls, n);
      chk_int({tag, ".done_cycle"}, done_at, n);
      chk_int({tag, ".done_pulses"}, done_cnt, 1);
      chk_int({tag, ".pc_release"}, free_at, n + 1);
   endtask

   initial begin
      // 1. reset with random inputs
      rst = 1'b1;
      drive_random(50);
      @(negedge clk);
      tick("rst1");
      drive_random(50);
      tick("rst2");
      chk("rst.pcWrite_const", o_pc, 1'b1);
      chk("rst.mdBusy_const", o_busy, 1'b0);
      rst = 1'b0;

      // 2. load-use on $t0, then $0 never stalls
      drive_zero();
      bus.memRead_ID_EX = 1'b1; bus.ctrlRegWrite_ID_EX = 1'b1; bus.rd_ID_EX = 5'd8; bus.rs_ID = 5'd8;
      tick("lu");
      chk("lu.bubble_const", o_bub, 1'b1);
      drive_zero();
      bus.memRead_EX_MEM = 1'b1; bus.rd_EX_MEM = 5'd8; bus.rs_ID = 5'd9;
      tick("lu_after");
      chk("lu_after.pc_const", o_pc, 1'b1);
      drive_zero();
      bus.memRead_ID_EX = 1'b1; bus.ctrlRegWrite_ID_EX = 1'b1; bus.rd_ID_EX = 5'd0;
      tick("lu_r0");
      chk("lu_r0.pc_const", o_pc, 1'b1);

      // 3. beq on $t1: add in EX, then lw-in-EX (load-use) followed by lw-in-MEM (branch stall)
      drive_zero();
      bus.branch_ID = 1'b1; bus.rs_ID = 5'd9; bus.rt_ID = 5'd10;
      bus.ctrlRegWrite_ID_EX = 1'b1; bus.rd_ID_EX = 5'd9;
      tick("br_add");
      chk("br_add.bubble_const", o_bub, 1'b1);
      bus.ctrlRegWrite_ID_EX = 1'b0; bus.rd_ID_EX = 5'd0;
      tick("br_add_clear");
      chk("br_add_clear.pc_const", o_pc, 1'b1);
      begin
         int total;
         total = 0;
         bus.memRead_ID_EX = 1'b1; bus.ctrlRegWrite_ID_EX = 1'b1; bus.rd_ID_EX = 5'd9;
         tick("br_lw_ex");
         if (!o_pc) total++;
         bus.memRead_ID_EX = 1'b0; bus.ctrlRegWrite_ID_EX = 1'b0; bus.rd_ID_EX = 5'd0;
         bus.memRead_EX_MEM = 1'b1; bus.rd_EX_MEM = 5'd9;
         tick("br_lw_mem");
         if (!o_pc) total++;
         bus.memRead_EX_MEM = 1'b0; bus.rd_EX_MEM = 5'd0;
         tick("br_lw_done");
         if (!o_pc) total++;
         chk_int("br_lw.total_stall", total, 2);
      end

      // 4. DIV then MULT occupancy
      md_run(1'b1, DIV_N, "div");
      md_run(1'b0, MULT_N, "mult");

      // 5. taken branch with simultaneous load-use: flush deferred one cycle
      drive_zero();
      bus.branchTaken_ID = 1'b1; bus.memRead_ID_EX = 1'b1; bus.rd_ID_EX = 5'd8; bus.rt_ID = 5'd8;
      tick("flush_lu");
      chk("flush_lu.flush_const", o_flush, 1'b0);
      bus.memRead_ID_EX = 1'b0; bus.rd_ID_EX = 5'd0;
      tick("flush_next");
      chk("flush_next.flush_const", o_flush, 1'b1);

      // 6. reset in cycle 10 of a DIV, then a fresh MULT
      drive_zero();
      bus.mdStart_EX = 1'b1; bus.mdIsDiv_EX = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         tick("div_abort");
         drive_zero();
      end
      rst = 1'b1;
      tick("div_rst");
      chk("div_rst.done_const", o_done, 1'b0);
      rst = 1'b0;
      tick("div_post_rst");
      chk("div_post_rst.busy_const", o_busy, 1'b0);
      chk("div_post_rst.done_const", o_done, 1'b0);
      md_run(1'b0, MULT_N, "mult_after_rst");

      // Random traffic against the model, with occasional resets
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 99) < 2);
         drive_random(6);
         tick("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
